// File: rtl/data_mem_ctrl_if.sv
// Request/response handshake bundle between the memory stage and data_mem_ctrl.
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I byte-lane data memory with configurable read latency and error responses.
// One transaction in flight; stores commit on the accept edge.
module data_mem_ctrl #(
  parameter int    ADDR_WIDTH   = 17,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state;
  logic [2:0]              cnt;
  logic [31:0]             load_q;
  logic [31:0]             mem [DEPTH];

  logic [ADDR_WIDTH-3:0]   widx;
  logic [1:0]              off;
  logic                    acc_err;
  logic                    accept;
  logic                    store_en;
  logic [3:0]              be;
  logic [31:0]             wlane;
  logic [31:0]             rword;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [31:0]             load_val;

  assign widx     = bus.req_addr[ADDR_WIDTH-1:2];
  assign off      = bus.req_addr[1:0];
  assign accept   = bus.req_ready && bus.req_valid;
  assign store_en = accept && bus.req_we && !acc_err;

  always_comb begin
    acc_err = 1'b0;
    if (bus.req_funct3[1:0] == 2'b01 && off[0])
      acc_err = 1'b1;
    if (bus.req_funct3[1:0] == 2'b10 && off != 2'b00)
      acc_err = 1'b1;
    if (bus.req_addr[31:ADDR_WIDTH] != '0)
      acc_err = 1'b1;
    if (bus.req_we) begin
      if (bus.req_funct3 >= 3'd3)
        acc_err = 1'b1;
    end else if (bus.req_funct3 == 3'd3 || bus.req_funct3 == 3'd6 ||
                 bus.req_funct3 == 3'd7) begin
      acc_err = 1'b1;
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick placement.
  always_comb begin
    be    = 4'b1111;
    wlane = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wlane = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = bus.req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i])
          mem[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_comb begin
    rword    = mem[widx];
    byte_sel = rword[{off, 3'b000} +: 8];
    half_sel = off[1] ? rword[31:16] : rword[15:0];
    case (bus.req_funct3)
      3'd0:    load_val = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_val = {{16{half_sel[15]}}, half_sel};
      3'd2:    load_val = rword;
      3'd4:    load_val = {24'b0, byte_sel};
      3'd5:    load_val = {16'b0, half_sel};
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      load_q        <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.req_ready <= 1'b0;
            if (acc_err || bus.req_we) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= '0;
              bus.rsp_err   <= acc_err;
            end else if (READ_LATENCY == 1) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= load_val;
              bus.rsp_err   <= 1'b0;
            end else begin
              state  <= BUSY;
              cnt    <= 3'(READ_LATENCY - 1);
              load_q <= load_val;
            end
          end
        end
        BUSY: begin
          if (cnt == 3'd1) begin
            state         <= RESP;
            cnt           <= '0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= load_q;
            bus.rsp_err   <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance at READ_LATENCY 1, one at 3.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        drv_valid;
    logic        drv_we;
    logic [2:0]  drv_f3;
    logic [31:0] drv_addr;
    logic [31:0] drv_wdata;
    logic        drv_rsp_ready;

    logic        c_req_ready;
    logic        c_rsp_valid;
    logic [31:0] c_rdata;
    logic        c_err;

    int n_checks;
    int n_fail;

    data_mem_ctrl_if if1 ();
    data_mem_ctrl_if if3 ();

    assign if1.req_valid  = drv_valid & ~sel;
    assign if3.req_valid  = drv_valid & sel;
    assign if1.rsp_ready  = drv_rsp_ready & ~sel;
    assign if3.rsp_ready  = drv_rsp_ready & sel;
    assign if1.req_we     = drv_we;
    assign if3.req_we     = drv_we;
    assign if1.req_funct3 = drv_f3;
    assign if3.req_funct3 = drv_f3;
    assign if1.req_addr   = drv_addr;
    assign if3.req_addr   = drv_addr;
    assign if1.req_wdata  = drv_wdata;
    assign if3.req_wdata  = drv_wdata;

    always_comb begin
        c_req_ready = sel ? if3.req_ready : if1.req_ready;
        c_rsp_valid = sel ? if3.rsp_valid : if1.rsp_valid;
        c_rdata     = sel ? if3.rsp_rdata : if1.rsp_rdata;
        c_err       = sel ? if3.rsp_err   : if1.rsp_err;
    end

    data_mem_ctrl #(.ADDR_WIDTH(17), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    data_mem_ctrl #(.ADDR_WIDTH(17), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic txn(input logic s, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        sel           = s;
        drv_we        = we;
        drv_f3        = f3;
        drv_addr      = a;
        drv_wdata     = wd;
        drv_valid     = 1'b1;
        drv_rsp_ready = 1'b0;
        @(negedge clk);
        drv_valid = 1'b0;
        lat = 1;
        while (!c_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("rsp_valid_seen", 32'(c_rsp_valid), 32'd1);
        rd = c_rdata;
        er = c_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_rdata", c_rdata, rd);
            check_eq("hold_req_ready", 32'(c_req_ready), 32'd0);
        end
        drv_rsp_ready = 1'b1;
        @(negedge clk);
        drv_rsp_ready = 1'b0;
        check_eq("ready_after_rsp", 32'(c_req_ready), 32'd1);
        check_eq("valid_after_rsp", 32'(c_rsp_valid), 32'd0);
    endtask

    task automatic chk(input string tag, input logic s, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int hold,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(s, we, f3, a, wd, hold, rd, er, lat);
        check_eq({tag, "_rdata"}, rd, exp_rd);
        check_eq({tag, "_err"}, 32'(er), 32'(exp_err));
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        sel           = 1'b0;
        drv_valid     = 1'b0;
        drv_we        = 1'b0;
        drv_f3        = 3'd0;
        drv_addr      = '0;
        drv_wdata     = '0;
        drv_rsp_ready = 1'b0;

        #12;
        check_eq("rst_req_ready", 32'(if1.req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(if1.rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", if1.rsp_rdata, 32'd0);
        check_eq("rst_rsp_err", 32'(if1.rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store then load, single-cycle latency
        chk("sw_100",  1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1);
        chk("lw_100",  1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1);

        // Byte store and sub-word loads
        chk("sb_101",  1'b0, 1'b1, 3'd0, 32'h101, 32'h0000007F, 0, 32'h0, 1'b0, 1);
        chk("lb_103",  1'b0, 1'b0, 3'd0, 32'h103, 32'h0, 0, 32'hFFFFFFDE, 1'b0, 1);
        chk("lbu_103", 1'b0, 1'b0, 3'd4, 32'h103, 32'h0, 0, 32'h000000DE, 1'b0, 1);
        chk("lh_102",  1'b0, 1'b0, 3'd1, 32'h102, 32'h0, 0, 32'hFFFFDEAD, 1'b0, 1);
        chk("lhu_102", 1'b0, 1'b0, 3'd5, 32'h102, 32'h0, 0, 32'h0000DEAD, 1'b0, 1);
        chk("lw_100b", 1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEAD7FEF, 1'b0, 1);
        chk("lb_101",  1'b0, 1'b0, 3'd0, 32'h101, 32'h0, 0, 32'h0000007F, 1'b0, 1);

        // Faulting accesses leave memory untouched
        chk("lw_mis",  1'b0, 1'b0, 3'd2, 32'h102, 32'h0, 0, 32'h0, 1'b1, 1);
        chk("sh_mis",  1'b0, 1'b1, 3'd1, 32'h101, 32'h0000FFFF, 0, 32'h0, 1'b1, 1);
        chk("lw_oor",  1'b0, 1'b0, 3'd2, 32'h0002_0000, 32'h0, 0, 32'h0, 1'b1, 1);
        chk("sw_oor",  1'b0, 1'b1, 3'd2, 32'h0002_0100, 32'h11111111, 0, 32'h0, 1'b1, 1);
        chk("ld_f3_3", 1'b0, 1'b0, 3'd3, 32'h100, 32'h0, 0, 32'h0, 1'b1, 1);
        chk("st_f3_3", 1'b0, 1'b1, 3'd3, 32'h100, 32'h22222222, 0, 32'h0, 1'b1, 1);
        chk("lw_after_err", 1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEAD7FEF, 1'b0, 1);

        // Upper half store
        chk("sh_102",  1'b0, 1'b1, 3'd1, 32'h102, 32'h1234BEEF, 0, 32'h0, 1'b0, 1);
        chk("lw_100c", 1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hBEEF7FEF, 1'b0, 1);

        // Three-cycle latency with a stalled consumer
        chk("sw3_200", 1'b1, 1'b1, 3'd2, 32'h200, 32'h12345678, 0, 32'h0, 1'b0, 1);
        chk("lw3_200", 1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 5, 32'h12345678, 1'b0, 3);

        // Asynchronous reset while the load is in BUSY
        @(negedge clk);
        sel       = 1'b1;
        drv_we    = 1'b0;
        drv_f3    = 3'd2;
        drv_addr  = 32'h200;
        drv_valid = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        check_eq("busy_req_ready", 32'(if3.req_ready), 32'd0);
        check_eq("busy_rsp_valid", 32'(if3.rsp_valid), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_req_ready", 32'(if3.req_ready), 32'd1);
        check_eq("arst_rsp_valid", 32'(if3.rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rsp_valid", 32'(if3.rsp_valid), 32'd0);

        chk("lw3_post_rst", 1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 0, 32'h12345678, 1'b0, 3);
        chk("lw1_post_rst", 1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hBEEF7FEF, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
